// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: sync, clock glitch filter, frame FSM, set-2 prefix layer.
// Build option: define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 48000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          dat;
  logic          clk_f;
  logic [FW-1:0] fcnt;
  logic          fall;
  state_t        state;
  state_t        state_nxt;
  logic [7:0]    sh;
  logic [2:0]    bcnt;
  logic [WW-1:0] wd;
  logic          tmo;
  logic          accept;
  logic          ferr;
  logic          par_ok;
  logic          ext;
  logic          brk;
  logic [2:0]    skip;
  logic          resp;

  assign dat = dat_sync[1];

`ifdef PS2_PARITY_CHECK_EN
  logic par;
  assign par_ok = ^{sh, par};
`else
  assign par_ok = 1'b1;
`endif

  // Two-flop synchronisers for both raw lines; idle level is high.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  // Clock filter: follow the line only after FILTER_LEN differing samples in a row.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_f <= 1'b1;
      fcnt  <= '0;
      fall  <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_sync[1] == clk_f) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILTER_LEN - 1)) begin
        clk_f <= clk_sync[1];
        fcnt  <= '0;
        fall  <= clk_f;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  // Frame state register.
  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Frame next-state, byte accept and framing-error decode.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    ferr      = 1'b0;
    tmo       = (state != IDLE) && (wd == WW'(TIMEOUT_CYCLES));
    if (tmo) begin
      state_nxt = IDLE;
    end else if (fall) begin
      unique case (state)
        IDLE:   if (!dat) state_nxt = DATA;
        DATA:   if (bcnt == 3'd7) state_nxt = PARITY;
        PARITY: state_nxt = STOP;
        STOP: begin
          state_nxt = IDLE;
          if (dat && par_ok) accept = 1'b1;
          else               ferr   = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Shift register, bit counter, parity capture and inactivity watchdog.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sh   <= '0;
      bcnt <= '0;
      wd   <= '0;
`ifdef PS2_PARITY_CHECK_EN
      par  <= 1'b0;
`endif
    end else begin
      if (state == IDLE || fall || tmo) wd <= '0;
      else                              wd <= wd + 1'b1;
      if (fall) begin
        case (state)
          IDLE: bcnt <= '0;
          DATA: begin
            sh   <= {dat, sh[7:1]};
            bcnt <= bcnt + 1'b1;
          end
`ifdef PS2_PARITY_CHECK_EN
          PARITY: par <= dat;
`endif
          default: ;
        endcase
      end
    end
  end

  // Frame-layer strobes, one cycle after the stop-bit fall event.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= accept;
      frame_err  <= ferr | tmo;
      if (accept) byte_data <= sh;
    end
  end

  assign resp = byte_data inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

  // Prefix layer: pause swallowing, E0/F0 flags, responses, key events.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ps2_key <= '0;
      ext     <= 1'b0;
      brk     <= 1'b0;
      skip    <= '0;
    end else if (tmo) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (byte_valid) begin
      priority case (1'b1)
        (skip != 3'd0):       skip <= skip - 1'b1;
        (byte_data == 8'hE1): skip <= 3'd7;
        (byte_data == 8'hE0): ext  <= 1'b1;
        (byte_data == 8'hF0): brk  <= 1'b1;
        resp: begin
          ext <= 1'b0;
          brk <= 1'b0;
        end
        default: begin
          ps2_key <= {~ps2_key[10], ~brk, ext, byte_data};
          ext     <= 1'b0;
          brk     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: table of frames plus timeout, glitch and reset cases.
// Expected bytes and key words go to queues and are matched as the DUT emits them.
module tb_ps2_key_decoder;

  localparam int HALF = 16;

  logic        clk_sys  = 1'b0;
  logic        reset    = 1'b1;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_err;

  ps2_key_decoder dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ps2_key    (ps2_key),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [7:0]  b;
    logic        flip;
    logic        bstop;
    logic        err;
    logic        has_key;
    logic [10:0] key;
  } vec_t;

  vec_t        tbl[21];
  int          total = 0;
  int          bad   = 0;
  int          errs  = 0;
  int          bytes = 0;
  int          e0;
  int          b0;
  logic [7:0]  bq[$];
  logic [10:0] kq[$];
  logic [10:0] prev_key = '0;

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, act, exp);
    end
  endtask

  // Scoreboard: match emitted bytes and key events against the queues.
  always @(negedge clk_sys) begin
    if (frame_err) errs++;
    if (byte_valid) begin
      bytes++;
      if (bq.size() == 0) chk("unexpected_byte", byte_data, 256);
      else                chk("byte", byte_data, bq.pop_front());
    end
    if (reset) begin
      prev_key = ps2_key;
    end else if (ps2_key != prev_key) begin
      if (kq.size() == 0) chk("unexpected_key", ps2_key, prev_key);
      else                chk("key", ps2_key, kq.pop_front());
      prev_key = ps2_key;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      cyc(HALF);
      ps2_clk = 1'b0;
      cyc(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic frame(input logic [7:0] b, input logic flip, input logic bstop);
    logic p;
    p = ~(^b) ^ flip;
    send_bits({~bstop, p, b, 1'b0}, 11);
    ps2_data = 1'b1;
    cyc(3 * HALF);
  endtask

  initial begin
    tbl[0]  = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 11'h61C};
    tbl[1]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000};
    tbl[2]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000};
    tbl[3]  = '{8'h75, 1'b0, 1'b0, 1'b0, 1'b1, 11'h175};
    tbl[4]  = '{8'hE1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000};
    tbl[5]  = '{8'h14, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000};
    tbl[6]  = '{8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000};
    tbl[7]  = '{8'hE1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000};
    tbl[8]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000};
    tbl[9]  = '{8'h14, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000};
    tbl[10] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000};
    tbl[11] = '{8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000};
    tbl[12] = '{8'h16, 1'b0, 1'b0, 1'b0, 1'b1, 11'h616};
    tbl[13] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000};
    tbl[14] = '{8'hFA, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000};
    tbl[15] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 11'h21C};
    tbl[16] = '{8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 11'h000};
    tbl[17] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000};
    tbl[18] = '{8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 11'h000};
    tbl[19] = '{8'h6B, 1'b0, 1'b0, 1'b0, 1'b1, 11'h76B};
`ifdef PS2_PARITY_CHECK_EN
    tbl[20] = '{8'h29, 1'b1, 1'b0, 1'b1, 1'b0, 11'h000};
`else
    tbl[20] = '{8'h29, 1'b1, 1'b0, 1'b0, 1'b1, 11'h229};
`endif

    cyc(4);
    @(negedge clk_sys);
    chk("rst_key", ps2_key, 0);
    chk("rst_valid", byte_valid, 0);
    chk("rst_data", byte_data, 0);
    chk("rst_err", frame_err, 0);
    cyc(1);
    reset = 1'b0;
    cyc(2 * HALF);

    for (int i = 0; i < 21; i++) begin
      e0 = errs;
      b0 = bytes;
      if (!tbl[i].err)    bq.push_back(tbl[i].b);
      if (tbl[i].has_key) kq.push_back(tbl[i].key);
      frame(tbl[i].b, tbl[i].flip, tbl[i].bstop);
      chk($sformatf("row%0d_err", i), errs - e0, int'(tbl[i].err));
      chk($sformatf("row%0d_bytes", i), bytes - b0, int'(!tbl[i].err));
      chk($sformatf("row%0d_keyq", i), kq.size(), 0);
    end

    bq.push_back(8'hE0);
    frame(8'hE0, 1'b0, 1'b0);
    e0 = errs;
    b0 = bytes;
    send_bits(11'b000_0000_1010, 5);
    ps2_data = 1'b1;
    cyc(47900);
    chk("tmo_early", errs - e0, 0);
    cyc(300);
    chk("tmo_err", errs - e0, 1);
    chk("tmo_bytes", bytes - b0, 0);
    bq.push_back(8'h1C);
`ifdef PS2_PARITY_CHECK_EN
    kq.push_back(11'h21C);
`else
    kq.push_back(11'h61C);
`endif
    frame(8'h1C, 1'b0, 1'b0);
    chk("tmo_next_keyq", kq.size(), 0);
    chk("tmo_next_err", errs - e0, 1);

    e0 = errs;
    b0 = bytes;
    ps2_data = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ps2_clk = 1'b0;
      cyc(1);
      ps2_clk = 1'b1;
      cyc(3);
    end
    ps2_clk = 1'b0;
    cyc(6);
    ps2_clk = 1'b1;
    cyc(20);
    ps2_data = 1'b1;
    cyc(2 * HALF);
    chk("glitch_bytes", bytes - b0, 0);
    bq.push_back(8'h2B);
`ifdef PS2_PARITY_CHECK_EN
    kq.push_back(11'h62B);
`else
    kq.push_back(11'h22B);
`endif
    frame(8'h2B, 1'b0, 1'b0);
    chk("glitch_next_bytes", bytes - b0, 1);
    chk("glitch_next_keyq", kq.size(), 0);
    chk("glitch_err", errs - e0, 0);

    send_bits(11'b000_0000_0110, 3);
    reset = 1'b1;
    cyc(1);
    @(negedge clk_sys);
    chk("mid_rst_key", ps2_key, 0);
    chk("mid_rst_valid", byte_valid, 0);
    chk("mid_rst_data", byte_data, 0);
    chk("mid_rst_err", frame_err, 0);
    cyc(2);
    reset    = 1'b0;
    ps2_data = 1'b1;
    cyc(2 * HALF);
    e0 = errs;
    b0 = bytes;
    bq.push_back(8'h1C);
    kq.push_back(11'h61C);
    frame(8'h1C, 1'b0, 1'b0);
    chk("post_rst_bytes", bytes - b0, 1);
    chk("post_rst_keyq", kq.size(), 0);
    chk("post_rst_err", errs - e0, 0);
    chk("byteq_empty", bq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
